// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: round-robin grant, FUNC3/alignment
// screening before the memory is touched, and a response watchdog against stalled consumers.
module dmem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic              REQ0_WE,
  input  logic [2:0]        REQ0_FUNC3,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_WDATA,
  output logic              RSP0_VALID,
  input  logic              RSP0_READY,
  output logic [DATA_W-1:0] RSP0_RDATA,
  output logic              RSP0_ERR,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic              REQ1_WE,
  input  logic [2:0]        REQ1_FUNC3,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_WDATA,
  output logic              RSP1_VALID,
  input  logic              RSP1_READY,
  output logic [DATA_W-1:0] RSP1_RDATA,
  output logic              RSP1_ERR,
  output logic              MEM_MRD,
  output logic              MEM_MWRT,
  output logic [2:0]        MEM_FUNC3,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic              TIMEOUT_FLAG
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t             state_q;
  logic               ptr_q;
  logic               port_q;
  logic               we_q;
  logic               err_q;
  logic               tflag_q;
  logic [2:0]         f3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               idle;
  logic               any_vld;
  logic               grant_d;
  logic               we_d;
  logic [2:0]         f3_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic               illegal_d;
  logic               rsp_rdy;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    if (we) bad = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else    bad = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    if (f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
    if (f3 == 3'b010 && a != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  assign idle    = (state_q == S_IDLE) && !RESET;
  assign any_vld = REQ0_VALID | REQ1_VALID;

  // Pointer port wins a tie; otherwise whichever port is asking.
  always_comb begin
    grant_d = 1'b0;
    if (ptr_q) grant_d = REQ1_VALID ? 1'b1 : 1'b0;
    else       grant_d = REQ0_VALID ? 1'b0 : 1'b1;
  end

  assign we_d      = grant_d ? REQ1_WE    : REQ0_WE;
  assign f3_d      = grant_d ? REQ1_FUNC3 : REQ0_FUNC3;
  assign addr_d    = grant_d ? REQ1_ADDR  : REQ0_ADDR;
  assign wdata_d   = grant_d ? REQ1_WDATA : REQ0_WDATA;
  assign illegal_d = is_illegal(we_d, f3_d, addr_d[1:0]);
  assign rsp_rdy   = port_q ? RSP1_READY : RSP0_READY;

  assign REQ0_READY = idle & any_vld & ~grant_d;
  assign REQ1_READY = idle & any_vld &  grant_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      tflag_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_vld) begin
            port_q  <= grant_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= illegal_d;
            state_q <= illegal_d ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          rdata_q <= we_q ? '0 : MEM_RDATA;
          cnt_q   <= '0;
          state_q <= S_RESP;
        end
        S_RESP: begin
          // Either the consumer takes the response or the watchdog drops it.
          if (rsp_rdy) begin
            state_q <= S_IDLE;
            ptr_q   <= ~port_q;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= S_IDLE;
            ptr_q   <= ~port_q;
            tflag_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are qualified by RESET so an aborted store never reaches the array.
  assign MEM_MRD   = (state_q == S_ACCESS) & ~we_q & ~RESET;
  assign MEM_MWRT  = (state_q == S_ACCESS) &  we_q & ~RESET;
  assign MEM_FUNC3 = f3_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;

  assign RSP0_VALID = (state_q == S_RESP) & ~port_q;
  assign RSP1_VALID = (state_q == S_RESP) &  port_q;
  assign RSP0_RDATA = RSP0_VALID ? rdata_q : '0;
  assign RSP1_RDATA = RSP1_VALID ? rdata_q : '0;
  assign RSP0_ERR   = RSP0_VALID & err_q;
  assign RSP1_ERR   = RSP1_VALID & err_q;

  assign BUSY         = (state_q != S_IDLE);
  assign TIMEOUT_FLAG = tflag_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-addressed RISC-V style memory model.
module tb_dmem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_ready [2];

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_mrd, mem_mwrt, busy, tflag;
  logic [2:0]  mem_f3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_rdata [2];

  assign req_ready[0] = req0_ready;
  assign req_ready[1] = req1_ready;
  assign rsp_valid[0] = rsp0_valid;
  assign rsp_valid[1] = rsp1_valid;
  assign rsp_err[0]   = rsp0_err;
  assign rsp_err[1]   = rsp1_err;
  assign rsp_rdata[0] = rsp0_rdata;
  assign rsp_rdata[1] = rsp1_rdata;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RSP_TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(req_valid[0]), .REQ0_READY(req0_ready), .REQ0_WE(req_we[0]),
    .REQ0_FUNC3(req_f3[0]), .REQ0_ADDR(req_addr[0]), .REQ0_WDATA(req_wdata[0]),
    .RSP0_VALID(rsp0_valid), .RSP0_READY(rsp_ready[0]), .RSP0_RDATA(rsp0_rdata), .RSP0_ERR(rsp0_err),
    .REQ1_VALID(req_valid[1]), .REQ1_READY(req1_ready), .REQ1_WE(req_we[1]),
    .REQ1_FUNC3(req_f3[1]), .REQ1_ADDR(req_addr[1]), .REQ1_WDATA(req_wdata[1]),
    .RSP1_VALID(rsp1_valid), .RSP1_READY(rsp_ready[1]), .RSP1_RDATA(rsp1_rdata), .RSP1_ERR(rsp1_err),
    .MEM_MRD(mem_mrd), .MEM_MWRT(mem_mwrt), .MEM_FUNC3(mem_f3), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .BUSY(busy), .TIMEOUT_FLAG(tflag)
  );

  always #5 CLK = ~CLK;

  // Memory model: little-endian bytes, combinational read, write on posedge.
  logic [7:0] mem [256];
  logic       mem_clr;
  logic [7:0] ma0, ma1, ma2, ma3;
  int         strobes = 0;

  assign ma0 = mem_addr[7:0];
  assign ma1 = ma0 + 8'd1;
  assign ma2 = ma0 + 8'd2;
  assign ma3 = ma0 + 8'd3;

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_f3)
      3'b000:  mem_rdata = {{24{mem[ma0][7]}}, mem[ma0]};
      3'b001:  mem_rdata = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
      3'b010:  mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
      3'b100:  mem_rdata = {24'h0, mem[ma0]};
      3'b101:  mem_rdata = {16'h0, mem[ma1], mem[ma0]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_mwrt) begin
      case (mem_f3[1:0])
        2'b00: mem[ma0] <= mem_wdata[7:0];
        2'b01: begin mem[ma0] <= mem_wdata[7:0]; mem[ma1] <= mem_wdata[15:8]; end
        default: begin
          mem[ma0] <= mem_wdata[7:0];   mem[ma1] <= mem_wdata[15:8];
          mem[ma2] <= mem_wdata[23:16]; mem[ma3] <= mem_wdata[31:24];
        end
      endcase
    end
    if (mem_mrd || mem_mwrt) strobes <= strobes + 1;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One request on port p, then its response: handshake, latency, data, error, release.
  task automatic xact(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                      input string tag);
    bit got;
    int lat;
    req_valid[p] = 1'b1; req_we[p] = we; req_f3[p] = f3; req_addr[p] = a; req_wdata[p] = wd;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (req_ready[p]) got = 1;
      @(posedge CLK); #1;
    end
    req_valid[p] = 1'b0;
    chk({tag, "_hs"}, 32'(got), 32'd1);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge CLK);
      if (rsp_valid[p]) lat = k;
    end
    chk({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
    chk({tag, "_rdata"}, rsp_rdata[p], exp_rd);
    chk({tag, "_err"}, 32'(rsp_err[p]), 32'(exp_err));
    rsp_ready[p] = 1'b1;
    @(posedge CLK); #1;
    rsp_ready[p] = 1'b0;
    @(negedge CLK);
    chk({tag, "_done"}, 32'(rsp_valid[p]), 32'd0);
  endtask

  int gq[$];
  int dbl, rep, cnt, bad, s0, lat;
  bit done, got;

  initial begin
    RESET = 1'b1; mem_clr = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 0; req_we[p] = 0; req_f3[p] = 0; req_addr[p] = 0; req_wdata[p] = 0;
      rsp_ready[p] = 0;
    end
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0; mem_clr = 1'b0;
    @(negedge CLK);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp0", 32'(rsp0_valid), 0);
    chk("rst_rsp1", 32'(rsp1_valid), 0);
    chk("rst_flag", 32'(tflag), 0);
    chk("rst_strobe", 32'(mem_mrd | mem_mwrt), 0);

    // Store then load back on port 0
    xact(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "t1_sw");
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "t1_lw");

    // Illegal accesses never strobe the memory
    s0 = strobes;
    xact(1, 1'b0, 3'b001, 32'h13, 32'h0, 1'b1, 32'h0, "t3_lh_mis");
    xact(1, 1'b1, 3'b010, 32'h22, 32'h12345678, 1'b1, 32'h0, "t3_sw_mis");
    xact(0, 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, "t3_ld_f3");
    xact(1, 1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0, "t3_st_f3");
    chk("t3_no_strobe", 32'(strobes - s0), 0);
    xact(1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, "t3_lhu");
    xact(1, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, "t3_lh");
    xact(0, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, "t3_lb");

    // Both ports requesting continuously from reset
    RESET = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1; req_we[p] = 0; req_f3[p] = 3'b010; rsp_ready[p] = 1;
    end
    req_addr[0] = 32'h10; req_addr[1] = 32'h40;
    @(posedge CLK); #1 RESET = 1'b0;
    dbl = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      if (req_valid[0] && req_ready[0]) gq.push_back(0);
      if (req_valid[1] && req_ready[1]) gq.push_back(1);
      if (req_ready[0] && req_ready[1]) dbl++;
    end
    req_valid[0] = 0; req_valid[1] = 0;
    repeat (4) @(posedge CLK);
    #1 rsp_ready[0] = 0; rsp_ready[1] = 0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_grant%0d", i), (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF, 32'(i % 2));
    rep = 0;
    for (int i = 1; i < gq.size(); i++) if (gq[i] == gq[i-1]) rep++;
    chk("t2_repeat", 32'(rep), 0);
    chk("t2_both_ready", 32'(dbl), 0);

    // Watchdog drops an unconsumed response; the waiting port is then served
    req_valid[0] = 1; req_we[0] = 0; req_f3[0] = 3'b010; req_addr[0] = 32'h10;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (req_ready[0]) got = 1;
      @(posedge CLK); #1;
    end
    req_valid[0] = 0;
    req_valid[1] = 1; req_we[1] = 0; req_f3[1] = 3'b010; req_addr[1] = 32'h10;
    chk("t4_hs", 32'(got), 1);
    chk("t4_flag_pre", 32'(tflag), 0);
    cnt = 0; bad = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (rsp_valid[0]) begin
        cnt++;
        if (req_ready[1]) bad++;
      end else if (cnt > 0) done = 1;
    end
    chk("t4_valid_cycles", 32'(cnt), 4);
    chk("t4_early_grant", 32'(bad), 0);
    chk("t4_flag", 32'(tflag), 1);
    chk("t4_p1_grant", 32'(req_ready[1]), 1);
    @(posedge CLK); #1 req_valid[1] = 0;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge CLK);
      if (rsp_valid[1]) lat = k;
    end
    chk("t4_p1_lat", 32'(lat), 2);
    chk("t4_p1_rdata", rsp_rdata[1], 32'hDEADBEEF);
    rsp_ready[1] = 1;
    @(posedge CLK); #1 rsp_ready[1] = 0;

    // Reset during the store's access cycle aborts it
    req_valid[0] = 1; req_we[0] = 1; req_f3[0] = 3'b000; req_addr[0] = 32'h40; req_wdata[0] = 32'hAB;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (req_ready[0]) got = 1;
      @(posedge CLK); #1;
    end
    req_valid[0] = 0;
    RESET = 1'b1;
    chk("t5_hs", 32'(got), 1);
    @(negedge CLK);
    chk("t5_busy_access", 32'(busy), 1);
    chk("t5_mwrt_gated", 32'(mem_mwrt), 0);
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    chk("t5_busy_after", 32'(busy), 0);
    chk("t5_flag_cleared", 32'(tflag), 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid[0] || rsp_valid[1]) bad++;
      @(negedge CLK);
    end
    chk("t5_no_rsp", 32'(bad), 0);
    xact(0, 1'b0, 3'b100, 32'h40, 32'h0, 1'b0, 32'h00, "t5_readback");

    // Byte stores and sign/zero-extending byte loads
    xact(0, 1'b1, 3'b010, 32'h40, 32'h80000000, 1'b0, 32'h0, "t6_sw");
    xact(0, 1'b1, 3'b000, 32'h41, 32'h0000005A, 1'b0, 32'h0, "t6_sb");
    xact(1, 1'b0, 3'b100, 32'h41, 32'h0, 1'b0, 32'h0000005A, "t6_lbu");
    xact(0, 1'b0, 3'b000, 32'h43, 32'h0, 1'b0, 32'hFFFFFF80, "t6_lb");
    xact(1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h80005A00, "t6_lw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

endmodule
